rst_sequencer: RTL and testbench

- Parametrised reset/bring-up sequencer. Takes one raw asynchronous board/bench reset and drives NUM_CH staged, synchronously released active-high resets to core sub-blocks (e.g. cpu, mem_ctrl, io), with a ready flag.
- Instantiated directly under riscv_top. In simulation the bench drives only clk and rst.
- Replaces ad hoc single-reset bring-up with a software-re-triggerable, staggered sequence.

---
 rtl/rst_sequencer.sv | 135 +++++++++++++
 tb/tb_rst_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rst_sequencer.sv
// Staged reset/bring-up sequencer: synchronised release, hold, staggered per-channel release.
// Optional watchdog re-sequence enabled by defining RST_SEQ_WATCHDOG_EN.
module rst_sequencer #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned STAGGER     = 2,
  parameter int unsigned WDT_LIMIT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_rst,
  input  logic              heartbeat,
  output logic [NUM_CH-1:0] ch_rst,
  output logic              rdy,
  output logic              seq_busy,
  output logic              wdt_fired
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned SW = $clog2(STAGGER + 1);
  localparam int unsigned IW = $clog2(NUM_CH + 1);

  typedef enum logic [1:0] {StAssert, StHold, StRelease, StRun} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic [HW-1:0]          hold_cnt_q;
  logic [SW-1:0]          stg_cnt_q;
  logic [IW-1:0]          idx_q;
  logic                   wdt_timeout;
  logic                   resequence;

  // Leave ASSERT on the same edge the synchroniser output rises.
  assign sync_d     = {sync_q[SYNC_STAGES-2:0], 1'b1};
  assign resequence = (state_q != StAssert) && (sw_rst || wdt_timeout);

`ifdef RST_SEQ_WATCHDOG_EN
  localparam int unsigned WW = $clog2(WDT_LIMIT);

  logic [WW-1:0] wdt_cnt_q;

  assign wdt_timeout = (state_q == StRun) && !heartbeat && (wdt_cnt_q == WW'(WDT_LIMIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdt_cnt_q <= '0;
      wdt_fired <= 1'b0;
    end else begin
      if (state_q == StRun && !heartbeat && !wdt_timeout && !sw_rst) begin
        wdt_cnt_q <= wdt_cnt_q + WW'(1);
      end else begin
        wdt_cnt_q <= '0;
      end
      if (wdt_timeout) begin
        wdt_fired <= 1'b1;
      end
    end
  end
`else
  logic unused_heartbeat;

  assign unused_heartbeat = heartbeat;
  assign wdt_timeout      = 1'b0;
  assign wdt_fired        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StAssert;
      sync_q     <= '0;
      hold_cnt_q <= '0;
      stg_cnt_q  <= '0;
      idx_q      <= '0;
      ch_rst     <= '1;
      rdy        <= 1'b0;
      seq_busy   <= 1'b1;
    end else begin
      sync_q <= sync_d;
      if (resequence) begin
        state_q    <= StHold;
        hold_cnt_q <= '0;
        stg_cnt_q  <= '0;
        idx_q      <= '0;
        ch_rst     <= '1;
        rdy        <= 1'b0;
        seq_busy   <= 1'b1;
      end else begin
        unique case (state_q)
          StAssert: begin
            if (sync_d[SYNC_STAGES-1]) begin
              state_q    <= StHold;
              hold_cnt_q <= '0;
            end
          end
          StHold: begin
            if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) begin
              ch_rst[0] <= 1'b0;
              if (NUM_CH == 1) begin
                state_q  <= StRun;
                rdy      <= 1'b1;
                seq_busy <= 1'b0;
              end else begin
                state_q   <= StRelease;
                idx_q     <= IW'(1);
                stg_cnt_q <= '0;
              end
            end else begin
              hold_cnt_q <= hold_cnt_q + HW'(1);
            end
          end
          StRelease: begin
            if (stg_cnt_q == SW'(STAGGER - 1)) begin
              ch_rst[idx_q] <= 1'b0;
              stg_cnt_q     <= '0;
              if (idx_q == IW'(NUM_CH - 1)) begin
                state_q  <= StRun;
                rdy      <= 1'b1;
                seq_busy <= 1'b0;
              end else begin
                idx_q <= idx_q + IW'(1);
              end
            end else begin
              stg_cnt_q <= stg_cnt_q + SW'(1);
            end
          end
          StRun: ;
          default: state_q <= StAssert;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer: default 3-channel instance plus a 1-channel, 1-cycle-hold one.
module tb_rst_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sw_rst = 1'b0;
  logic       heartbeat = 1'b0;
  logic [2:0] ch_rst;
  logic       rdy, seq_busy, wdt_fired;

  logic       sw_rst1 = 1'b0;
  logic       hb1 = 1'b0;
  logic [0:0] ch_rst1;
  logic       rdy1, seq_busy1, wdt_fired1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rst_sequencer #(
    .NUM_CH(3), .SYNC_STAGES(2), .HOLD_CYCLES(4), .STAGGER(2), .WDT_LIMIT(8)
  ) u_dut (
    .clk(clk), .rst(rst), .sw_rst(sw_rst), .heartbeat(heartbeat),
    .ch_rst(ch_rst), .rdy(rdy), .seq_busy(seq_busy), .wdt_fired(wdt_fired)
  );

  rst_sequencer #(
    .NUM_CH(1), .SYNC_STAGES(2), .HOLD_CYCLES(1), .STAGGER(2), .WDT_LIMIT(1024)
  ) u_dut1 (
    .clk(clk), .rst(rst), .sw_rst(sw_rst1), .heartbeat(hb1),
    .ch_rst(ch_rst1), .rdy(rdy1), .seq_busy(seq_busy1), .wdt_fired(wdt_fired1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected ch_rst k edges after HOLD was entered with hold_cnt = 0.
  function automatic logic [2:0] seq_exp(input int k);
    logic [2:0] r;
    r = 3'b111;
    if (k >= 4) r[0] = 1'b0;
    if (k >= 6) r[1] = 1'b0;
    if (k >= 8) r[2] = 1'b0;
    return r;
  endfunction

  task automatic check_seq(input string tag, input int k);
    check({tag, "_ch"}, {29'd0, ch_rst}, {29'd0, seq_exp(k)});
    check({tag, "_rdy"}, {31'd0, rdy}, {31'd0, k >= 8});
    check({tag, "_busy"}, {31'd0, seq_busy}, {31'd0, k < 8});
  endtask

  // Release rst between edges, then follow E1..E10.
  task automatic power_on(input string tag);
    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check_seq(tag, e - 2);
    end
  endtask

  // One-cycle sw_rst pulse sampled on the next edge, then full sequence.
  task automatic sw_pulse_seq(input string tag);
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    check_seq(tag, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_seq(tag, k);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ch", {29'd0, ch_rst}, 32'h7);
    check("rst_rdy", {31'd0, rdy}, 32'h0);
    check("rst_busy", {31'd0, seq_busy}, 32'h1);
    check("rst_wdt", {31'd0, wdt_fired}, 32'h0);
    check("rst_ch1", {31'd0, ch_rst1}, 32'h1);

    // Power-on sequence; the 1-channel instance releases after E3.
    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check_seq("por", e - 2);
      if (e <= 4) begin
        check("one_ch", {31'd0, ch_rst1}, {31'd0, e < 3});
        check("one_rdy", {31'd0, rdy1}, {31'd0, e >= 3});
      end
    end

    sw_pulse_seq("swrun");

    // Abort mid-RELEASE with no clock edge.
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    for (int k = 1; k <= 6; k++) tick();
    check("pre_abort_ch", {29'd0, ch_rst}, 32'h4);
    #2;
    rst = 1'b0;
    #1;
    check("abort_ch", {29'd0, ch_rst}, 32'h7);
    check("abort_rdy", {31'd0, rdy}, 32'h0);
    check("abort_busy", {31'd0, seq_busy}, 32'h1);
    power_on("repor");

    // sw_rst at hold_cnt = 3, held high 5 cycles.
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    for (int k = 1; k <= 3; k++) tick();
    sw_rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("held_ch", {29'd0, ch_rst}, 32'h7);
    end
    sw_rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_seq("after_hold", k);
    end

`ifdef RST_SEQ_WATCHDOG_EN
    // Heartbeat every 5 cycles keeps the watchdog quiet.
    for (int c = 0; c < 100; c++) begin
      heartbeat = (c % 5 == 0);
      tick();
      if (c % 25 == 24) begin
        check("hb_wdt", {31'd0, wdt_fired}, 32'h0);
        check("hb_ch", {29'd0, ch_rst}, 32'h0);
      end
    end
    heartbeat = 1'b0;
    sw_pulse_seq("wdt_prep");
    for (int c = 1; c <= 8; c++) begin
      tick();
      check("wdt_fire", {31'd0, wdt_fired}, {31'd0, c >= 8});
      check("wdt_ch", {29'd0, ch_rst}, (c >= 8) ? 32'h7 : 32'h0);
    end
`else
    heartbeat = 1'b1;
    repeat (20) tick();
    heartbeat = 1'b0;
    repeat (20) tick();
    check("idle_wdt", {31'd0, wdt_fired}, 32'h0);
    check("idle_rdy", {31'd0, rdy}, 32'h1);
    check("idle_ch", {29'd0, ch_rst}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
